// File: rtl/lb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lb_pkg
//  Description : Shared definitions for the local-bus target router:
//                read FSM state encoding, default error data word, wait
//                counter width and the target-select field width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package lb_pkg;

  // Read FSM state encoding
  localparam logic [1:0] LB_ST_IDLE = 2'd0;
  localparam logic [1:0] LB_ST_WAIT = 2'd1;
  localparam logic [1:0] LB_ST_RESP = 2'd2;

  // Data returned for reads to a missing target or a timed-out target
  localparam logic [31:0] LB_ERR_DATA = 32'hDEAD_BEEF;

  // Width of the read wait counter
  localparam int LB_CNT_W = 16;

  // Width of the target-select address field; a single target still
  // decodes one bit so that the upper half of the space is a bad target.
  function automatic int lb_sel_width(input int n_tgt);
    return (n_tgt > 1) ? $clog2(n_tgt) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lb_sel_decode.sv
`default_nettype none
// ============================================================================
//  Module      : lb_sel_decode
//  Description : Target-select decode for the write and read address fields
//                plus the read-data / read-valid mux for the latched target.
//  Ports       : i_wr_field  - select field of the write address
//                i_rd_field  - select field of the read address
//                i_sel       - latched target index of the outstanding read
//                i_rd_data   - concatenated target read data (target k at k)
//                i_rd_dval   - per-target read data valid
//                o_wr_onehot - one-hot write target (all zero if bad target)
//                o_rd_onehot - one-hot read target (all zero if bad target)
//                o_rd_ok     - read field addresses an existing target
//                o_sel_data  - read data of target i_sel
//                o_sel_dval  - read valid of target i_sel
//  Revision    : 1.0 - initial release
// ============================================================================
module lb_sel_decode #(
  parameter int N_TGT  = 4,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]        i_wr_field,
  input  logic [SEL_W-1:0]        i_rd_field,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [N_TGT*DATA_W-1:0] i_rd_data,
  input  logic [N_TGT-1:0]        i_rd_dval,
  output logic [N_TGT-1:0]        o_wr_onehot,
  output logic [N_TGT-1:0]        o_rd_onehot,
  output logic                    o_rd_ok,
  output logic [DATA_W-1:0]       o_sel_data,
  output logic                    o_sel_dval
);

  logic w_wr_ok;

  // The select field can encode more indices than there are targets when
  // N_TGT is not a power of two; those indices are bad targets.
  assign w_wr_ok = (32'(i_wr_field) < 32'(N_TGT));
  assign o_rd_ok = (32'(i_rd_field) < 32'(N_TGT));

  for (genvar g = 0; g < N_TGT; g++) begin : g_onehot
    assign o_wr_onehot[g] = w_wr_ok && (i_wr_field == SEL_W'(g));
    assign o_rd_onehot[g] = o_rd_ok && (i_rd_field == SEL_W'(g));
  end

  always_comb begin
    o_sel_data = '0;
    o_sel_dval = 1'b0;
    for (int k = 0; k < N_TGT; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_sel_data = i_rd_data[k*DATA_W +: DATA_W];
        o_sel_dval = i_rd_dval[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lb_target_router.sv
`default_nettype none
// ============================================================================
//  Module      : lb_target_router
//  Description : Routes upstream local-bus writes and reads to one of N_TGT
//                register targets selected by an address field. Writes are
//                a one-cycle strobe; reads run a single-outstanding FSM with
//                a wait timeout that returns ERR_DATA.
//  Ports       : S_AXI_ACLK/S_AXI_ARESETN - clock, async active-low reset
//                i_rx_*   - upstream write strobe/address/data
//                i_tx_*   - upstream read request/address
//                o_tx_*   - upstream read data/valid pulse
//                o_wr_*   - downstream one-hot write strobe, shared addr/data
//                o_rd_*   - downstream one-hot read pulse, shared address
//                i_rd_*   - downstream per-target read data/valid
//                o_busy, o_timeout_cnt, o_overrun - status
//  Revision    : 1.0 - initial release
// ============================================================================
module lb_target_router
  import lb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                N_TGT    = 4,
  parameter int                SEL_LSB  = 8,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(LB_ERR_DATA)
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    i_rx_dval,
  input  logic [ADDR_W-1:0]       i_rx_addr,
  input  logic [DATA_W-1:0]       i_rx_data,
  input  logic                    i_tx_req,
  input  logic [ADDR_W-1:0]       i_tx_addr,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_tx_dval,
  output logic [N_TGT-1:0]        o_wr_en,
  output logic [ADDR_W-1:0]       o_wr_addr,
  output logic [DATA_W-1:0]       o_wr_data,
  output logic [N_TGT-1:0]        o_rd_req,
  output logic [ADDR_W-1:0]       o_rd_addr,
  input  logic [N_TGT*DATA_W-1:0] i_rd_data,
  input  logic [N_TGT-1:0]        i_rd_dval,
  output logic                    o_busy,
  output logic [7:0]              o_timeout_cnt,
  output logic                    o_overrun
);

  localparam int                c_SEL_W   = lb_sel_width(N_TGT);
  // Counter value in the TIMEOUT-th consecutive wait cycle without data
  localparam logic [LB_CNT_W-1:0] c_TO_LAST = LB_CNT_W'(TIMEOUT - 1);

  logic [c_SEL_W-1:0]  w_wr_field;
  logic [c_SEL_W-1:0]  w_rd_field;
  logic [N_TGT-1:0]    w_wr_onehot;
  logic [N_TGT-1:0]    w_rd_onehot;
  logic                w_rd_ok;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_dval;

  logic [1:0]          r_state;
  logic [c_SEL_W-1:0]  r_sel;
  logic [LB_CNT_W-1:0] r_cnt;
  logic [N_TGT-1:0]    r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [N_TGT-1:0]    r_rd_req;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_dval;
  logic [7:0]          r_timeout_cnt;
  logic                r_overrun;

  assign w_wr_field = i_rx_addr[SEL_LSB +: c_SEL_W];
  assign w_rd_field = i_tx_addr[SEL_LSB +: c_SEL_W];

  lb_sel_decode #(
    .N_TGT  (N_TGT),
    .DATA_W (DATA_W),
    .SEL_W  (c_SEL_W)
  ) u_sel_decode (
    .i_wr_field  (w_wr_field),
    .i_rd_field  (w_rd_field),
    .i_sel       (r_sel),
    .i_rd_data   (i_rd_data),
    .i_rd_dval   (i_rd_dval),
    .o_wr_onehot (w_wr_onehot),
    .o_rd_onehot (w_rd_onehot),
    .o_rd_ok     (w_rd_ok),
    .o_sel_data  (w_sel_data),
    .o_sel_dval  (w_sel_dval)
  );

  // Write path: independent of the read FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= i_rx_dval ? w_wr_onehot : '0;
      if (i_rx_dval) begin
        r_wr_addr <= i_rx_addr;
        r_wr_data <= i_rx_data;
      end
    end
  end

  // Read FSM, wait counter and status
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state       <= LB_ST_IDLE;
      r_sel         <= '0;
      r_cnt         <= '0;
      r_rd_req      <= '0;
      r_rd_addr     <= '0;
      r_tx_data     <= '0;
      r_tx_dval     <= 1'b0;
      r_timeout_cnt <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_rd_req  <= '0;
      r_tx_dval <= 1'b0;

      // Requests arriving while a read is outstanding are dropped
      if (i_tx_req && (r_state != LB_ST_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        LB_ST_IDLE: begin
          if (i_tx_req) begin
            r_rd_addr <= i_tx_addr;
            r_sel     <= w_rd_field;
            r_cnt     <= '0;
            if (w_rd_ok) begin
              r_rd_req <= w_rd_onehot;
              r_state  <= LB_ST_WAIT;
            end else begin
              r_state  <= LB_ST_RESP;
            end
          end
        end
        LB_ST_WAIT: begin
          // Target data takes priority over a timeout in the same cycle
          if (w_sel_dval) begin
            r_tx_data <= w_sel_data;
            r_tx_dval <= 1'b1;
            r_state   <= LB_ST_IDLE;
          end else if (r_cnt == c_TO_LAST) begin
            r_tx_data <= ERR_DATA;
            r_tx_dval <= 1'b1;
            r_state   <= LB_ST_IDLE;
            if (r_timeout_cnt != 8'hFF) begin
              r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LB_ST_RESP: begin
          r_tx_data <= ERR_DATA;
          r_tx_dval <= 1'b1;
          r_state   <= LB_ST_IDLE;
        end
        default: begin
          r_state <= LB_ST_IDLE;
        end
      endcase
    end
  end

  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_rd_req      = r_rd_req;
  assign o_rd_addr     = r_rd_addr;
  assign o_tx_data     = r_tx_data;
  assign o_tx_dval     = r_tx_dval;
  assign o_busy        = (r_state != LB_ST_IDLE);
  assign o_timeout_cnt = r_timeout_cnt;
  assign o_overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lb_target_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lb_target_router
//  Description : Bench for lb_target_router. Two instances share stimulus:
//                one with four targets, one with three (so that index 3 is a
//                bad target). A transaction-level model predicts every output
//                each cycle; directed sequences pin the model with literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lb_target_router;

  localparam int          TO  = 16;
  localparam int          SL  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         rx_dval = 1'b0;
  logic         tx_req  = 1'b0;
  logic [31:0]  rx_addr = '0;
  logic [31:0]  rx_data = '0;
  logic [31:0]  tx_addr = '0;
  logic [127:0] rd_data = '0;
  logic [3:0]   rd_dval = '0;

  logic [3:0]  o4_wr_en, o4_rd_req;
  logic [31:0] o4_wr_addr, o4_wr_data, o4_rd_addr, o4_tx_data;
  logic        o4_tx_dval, o4_busy, o4_overrun;
  logic [7:0]  o4_tocnt;

  logic [2:0]  o3_wr_en, o3_rd_req;
  logic [31:0] o3_wr_addr, o3_wr_data, o3_rd_addr, o3_tx_data;
  logic        o3_tx_dval, o3_busy, o3_overrun;
  logic [7:0]  o3_tocnt;

  lb_target_router #(.N_TGT(4), .SEL_LSB(SL), .TIMEOUT(TO)) dut4 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .i_rx_dval(rx_dval), .i_rx_addr(rx_addr), .i_rx_data(rx_data),
    .i_tx_req(tx_req), .i_tx_addr(tx_addr),
    .o_tx_data(o4_tx_data), .o_tx_dval(o4_tx_dval),
    .o_wr_en(o4_wr_en), .o_wr_addr(o4_wr_addr), .o_wr_data(o4_wr_data),
    .o_rd_req(o4_rd_req), .o_rd_addr(o4_rd_addr),
    .i_rd_data(rd_data), .i_rd_dval(rd_dval),
    .o_busy(o4_busy), .o_timeout_cnt(o4_tocnt), .o_overrun(o4_overrun));

  lb_target_router #(.N_TGT(3), .SEL_LSB(SL), .TIMEOUT(TO)) dut3 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .i_rx_dval(rx_dval), .i_rx_addr(rx_addr), .i_rx_data(rx_data),
    .i_tx_req(tx_req), .i_tx_addr(tx_addr),
    .o_tx_data(o3_tx_data), .o_tx_dval(o3_tx_dval),
    .o_wr_en(o3_wr_en), .o_wr_addr(o3_wr_addr), .o_wr_data(o3_wr_data),
    .o_rd_req(o3_rd_req), .o_rd_addr(o3_rd_addr),
    .i_rd_data(rd_data[95:0]), .i_rd_dval(rd_dval[2:0]),
    .o_busy(o3_busy), .o_timeout_cnt(o3_tocnt), .o_overrun(o3_overrun));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, (i == 0) ? 4 : 3,
               $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, 0, act, exp);
  endtask

  // ---------------- transaction-level model ----------------
  // A read accepted in cycle t0 owns the router until its response: a bad
  // target answers in t0+2; a good target answers the cycle after the first
  // of cycles t0+1..t0+TO carrying its valid, otherwise ERR in t0+TO+1.
  int          n_tgt [2] = '{4, 3};
  int          cyc = 0;
  bit          m_act [2];
  bit          m_good[2];
  int          m_t0  [2];
  int          m_sel [2];
  logic [3:0]  e_wr_en[2], e_rd_req[2];
  logic [31:0] e_wr_addr[2], e_wr_data[2], e_rd_addr[2], e_tx_data[2];
  bit          e_tx_dval[2], e_busy[2], e_ovr[2];
  int          e_tocnt[2];

  task automatic model_step(input int i);
    int ws, rs;
    if (!rst_n) begin
      m_act[i] = 0; e_wr_en[i] = 0; e_rd_req[i] = 0; e_wr_addr[i] = 0;
      e_wr_data[i] = 0; e_rd_addr[i] = 0; e_tx_data[i] = 0; e_tx_dval[i] = 0;
      e_busy[i] = 0; e_ovr[i] = 0; e_tocnt[i] = 0;
    end else begin
      ws = int'((rx_addr >> SL) & 32'd3);
      rs = int'((tx_addr >> SL) & 32'd3);
      e_wr_en[i] = (rx_dval && ws < n_tgt[i]) ? 4'(1 << ws) : 4'd0;
      if (rx_dval) begin
        e_wr_addr[i] = rx_addr;
        e_wr_data[i] = rx_data;
      end
      e_rd_req[i]  = 0;
      e_tx_dval[i] = 0;
      if (m_act[i]) begin
        if (tx_req) e_ovr[i] = 1;
        if (!m_good[i]) begin
          e_tx_data[i] = ERR; e_tx_dval[i] = 1; m_act[i] = 0;
        end else if (rd_dval[m_sel[i]]) begin
          e_tx_data[i] = rd_data[m_sel[i]*32 +: 32]; e_tx_dval[i] = 1; m_act[i] = 0;
        end else if (cyc - m_t0[i] == TO) begin
          e_tx_data[i] = ERR; e_tx_dval[i] = 1; m_act[i] = 0;
          if (e_tocnt[i] < 255) e_tocnt[i]++;
        end
      end else if (tx_req) begin
        m_act[i]     = 1;
        m_t0[i]      = cyc;
        m_sel[i]     = rs;
        m_good[i]    = (rs < n_tgt[i]);
        e_rd_addr[i] = tx_addr;
        e_rd_req[i]  = m_good[i] ? 4'(1 << rs) : 4'd0;
      end
      e_busy[i] = m_act[i];
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic cmp_inst(input int i, input logic [3:0] wr_en, input logic [31:0] wr_addr,
                          input logic [31:0] wr_data, input logic [3:0] rd_req,
                          input logic [31:0] rd_addr, input logic [31:0] tx_data,
                          input logic tx_dval, input logic busy, input logic [7:0] tocnt,
                          input logic ovr);
    bit z;
    z = !rst_n;
    chk("wr_en",   i, 32'(wr_en),   z ? 32'd0 : 32'(e_wr_en[i]));
    chk("wr_addr", i, wr_addr,      z ? 32'd0 : e_wr_addr[i]);
    chk("wr_data", i, wr_data,      z ? 32'd0 : e_wr_data[i]);
    chk("rd_req",  i, 32'(rd_req),  z ? 32'd0 : 32'(e_rd_req[i]));
    chk("rd_addr", i, rd_addr,      z ? 32'd0 : e_rd_addr[i]);
    chk("tx_data", i, tx_data,      z ? 32'd0 : e_tx_data[i]);
    chk("tx_dval", i, 32'(tx_dval), z ? 32'd0 : 32'(e_tx_dval[i]));
    chk("busy",    i, 32'(busy),    z ? 32'd0 : 32'(e_busy[i]));
    chk("tocnt",   i, 32'(tocnt),   z ? 32'd0 : 32'(e_tocnt[i]));
    chk("overrun", i, 32'(ovr),     z ? 32'd0 : 32'(e_ovr[i]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, o4_wr_en, o4_wr_addr, o4_wr_data, o4_rd_req, o4_rd_addr,
             o4_tx_data, o4_tx_dval, o4_busy, o4_tocnt, o4_overrun);
    cmp_inst(1, {1'b0, o3_wr_en}, o3_wr_addr, o3_wr_data, {1'b0, o3_rd_req}, o3_rd_addr,
             o3_tx_data, o3_tx_dval, o3_busy, o3_tocnt, o3_overrun);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    lit("rst_busy",    32'(o4_busy), 0);
    lit("rst_wr_en",   32'(o4_wr_en), 0);
    lit("rst_tx_dval", 32'(o4_tx_dval), 0);
    lit("rst_tocnt",   32'(o4_tocnt), 0);
    rst_n = 1'b1;
    tick();

    // Write to target 1
    rx_dval = 1; rx_addr = 32'h0000_0104; rx_data = 32'h1234_5678;
    tick();
    rx_dval = 0;
    lit("wr_en_c1",   32'(o4_wr_en), 32'h2);
    lit("wr_addr_c1", o4_wr_addr, 32'h0000_0104);
    lit("wr_data_c1", o4_wr_data, 32'h1234_5678);
    tick();
    lit("wr_en_c2",   32'(o4_wr_en), 0);
    lit("wr_hold",    o4_wr_data, 32'h1234_5678);

    // Read 0x300: target 3 on dut4, bad target on dut3
    tx_req = 1; tx_addr = 32'h0000_0300;
    tick();
    tx_req = 0;
    lit("rd_req_t3",  32'(o4_rd_req), 32'h8);
    lit("rd_addr",    o4_rd_addr, 32'h0000_0300);
    lit("busy_wait",  32'(o4_busy), 1);
    lit("bad_rd_req", 32'(o3_rd_req), 0);
    tick();
    lit("bad_dval",   32'(o3_tx_dval), 1);
    lit("bad_data",   o3_tx_data, ERR);
    lit("t3_nodval",  32'(o4_tx_dval), 0);
    tick(); tick(); tick();
    rd_dval = 4'b1000; rd_data[127:96] = 32'hA5A5_0003;
    tick();
    rd_dval = 0;
    lit("t3_dval",    32'(o4_tx_dval), 1);
    lit("t3_data",    o4_tx_data, 32'hA5A5_0003);
    lit("t3_busy",    32'(o4_busy), 0);
    tick();
    lit("t3_pulse",   32'(o4_tx_dval), 0);
    lit("t3_hold",    o4_tx_data, 32'hA5A5_0003);

    // Write to 0x300: no strobe on three-target instance
    rx_dval = 1; rx_addr = 32'h0000_0300; rx_data = 32'h0BAD_0300;
    tick();
    rx_dval = 0;
    lit("bad_wr_en",  32'(o3_wr_en), 0);
    lit("t3_wr_en",   32'(o4_wr_en), 32'h8);

    // Timeout on target 2
    tx_req = 1; tx_addr = 32'h0000_0200;
    tick();
    tx_req = 0;
    lit("rd_req_t2",  32'(o4_rd_req), 32'h4);
    repeat (TO - 1) tick();
    lit("to_early",   32'(o4_tx_dval), 0);
    tick();
    lit("to_dval",    32'(o4_tx_dval), 1);
    lit("to_data",    o4_tx_data, ERR);
    lit("to_cnt",     32'(o4_tocnt), 1);
    lit("to_cnt3",    32'(o3_tocnt), 1);

    // Overrun and non-selected valid during a read of target 0
    tx_req = 1; tx_addr = 32'h0000_0000;
    tick();
    tx_req = 1; tx_addr = 32'h0000_0100;
    rd_dval = 4'b0010; rd_data[63:32] = 32'h1111_0001;
    tick();
    tx_req = 0; rd_dval = 0;
    lit("ovr_set",    32'(o4_overrun), 1);
    lit("ovr_nodval", 32'(o4_tx_dval), 0);
    lit("ovr_busy",   32'(o4_busy), 1);
    rd_dval = 4'b0001; rd_data[31:0] = 32'h0000_0AAA;
    tick();
    rd_dval = 0;
    lit("t0_dval",    32'(o4_tx_dval), 1);
    lit("t0_data",    o4_tx_data, 32'h0000_0AAA);
    tick();
    lit("t0_single",  32'(o4_tx_dval), 0);
    lit("ovr_sticky", 32'(o4_overrun), 1);

    // Reset during a wait, then a late valid
    tx_req = 1; tx_addr = 32'h0000_0100;
    tick();
    tx_req = 0;
    tick();
    rst_n = 0;
    tick();
    lit("mr_busy",    32'(o4_busy), 0);
    lit("mr_tocnt",   32'(o4_tocnt), 0);
    lit("mr_ovr",     32'(o4_overrun), 0);
    rst_n = 1;
    rd_dval = 4'b0010; rd_data[63:32] = 32'h2222_0001;
    tick();
    rd_dval = 0;
    lit("late_dval",  32'(o4_tx_dval), 0);
    lit("late_busy",  32'(o4_busy), 0);
    tick();
    lit("late_dval2", 32'(o4_tx_dval), 0);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rx_dval = ($urandom_range(0, 3) == 0);
      rx_addr = $urandom;
      rx_data = $urandom;
      tx_req  = ($urandom_range(0, 2) == 0);
      tx_addr = $urandom;
      for (int k = 0; k < 4; k++) begin
        rd_dval[k] = (c < 1000) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 24) == 0);
        rd_data[k*32 +: 32] = $urandom;
      end
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1;

    // Silent targets: drive the timeout counter into saturation
    rd_dval = 0;
    for (int c = 0; c < 6000; c++) begin
      rx_dval = ($urandom_range(0, 3) == 0);
      rx_addr = $urandom;
      rx_data = $urandom;
      tx_req  = ($urandom_range(0, 1) == 0);
      tx_addr = $urandom;
      tick();
    end
    tx_req = 0; rx_dval = 0;
    repeat (TO + 4) tick();
    lit("to_sat4", 32'(o4_tocnt), 32'd255);
    lit("to_sat3", 32'(o3_tocnt), 32'd255);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lb_target_router.md
LB_TARGET_ROUTER -- requirements
Module: lb_target_router

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, local-bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, local-bus data width.
REQ-003 SHALL have parameter N_TGT, default 4, number of downstream register targets (1..8).
REQ-004 SHALL have parameter SEL_LSB, default 8, lowest address bit of the target-select field (width clog2(N_TGT), minimum 1).
REQ-005 SHALL have parameter TIMEOUT, default 255, read-wait limit in cycles (1..65535).
REQ-006 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, data returned on bad-target or timeout reads.
REQ-007 SHALL have one clock and an asynchronous, active-low reset: S_AXI_ACLK in 1 (clock) and S_AXI_ARESETN in 1 (reset).
REQ-008 Upstream write side: i_rx_dval in 1 (write strobe); i_rx_addr in ADDR_W; i_rx_data in DATA_W.
REQ-009 Upstream read side: i_tx_req in 1 (read request pulse); i_tx_addr in ADDR_W; o_tx_data out DATA_W; o_tx_dval out 1 (read data valid pulse).
REQ-010 Downstream write side: o_wr_en out N_TGT (one-hot strobe); o_wr_addr out ADDR_W; o_wr_data out DATA_W (both shared by all targets).
REQ-011 Downstream read side: o_rd_req out N_TGT (one-hot pulse); o_rd_addr out ADDR_W (shared); i_rd_data in N_TGT*DATA_W (target k at slice k); i_rd_dval in N_TGT.
REQ-012 Status: o_busy out 1 (read outstanding); o_timeout_cnt out 8 (saturating timeout count); o_overrun out 1 (sticky: request seen while busy).

Function
REQ-013 Target index SHALL be addr[SEL_LSB+clog2(N_TGT)-1:SEL_LSB]; an index >= N_TGT is a bad target.
REQ-014 Write: i_rx_dval at cycle 0 SHALL produce o_wr_en[sel]=1 for exactly cycle 1, with o_wr_addr/o_wr_data registered from cycle 0 and held until the next write.
REQ-015 A write to a bad target SHALL raise no o_wr_en bit; writes SHALL proceed independently of read FSM state.
REQ-016 Read FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE: i_tx_req at cycle 0 SHALL latch address and sel, drive o_rd_addr, pulse o_rd_req[sel] for exactly cycle 1, clear the wait counter, and enter WAIT.
REQ-018 IDLE with i_tx_req to a bad target SHALL raise no o_rd_req and SHALL enter RESP with ERR_DATA, giving o_tx_dval in cycle 2.
REQ-019 WAIT: i_rd_dval[sel] at cycle k SHALL load o_tx_data from slice sel and pulse o_tx_dval at cycle k+1, then return to IDLE.
REQ-020 WAIT SHALL ignore i_rd_dval from non-selected targets.
REQ-021 WAIT SHALL increment a 16-bit counter each cycle without a valid response; after TIMEOUT consecutive such cycles it SHALL return ERR_DATA with o_tx_dval on the next cycle and increment o_timeout_cnt (saturating at 255).
REQ-022 If i_rd_dval[sel] arrives in the same cycle the counter reaches TIMEOUT, the target data SHALL win and no timeout SHALL be counted.
REQ-023 o_tx_dval SHALL be a single-cycle pulse; o_tx_data SHALL hold its value until the next response.
REQ-024 o_busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-025 i_tx_req while not IDLE SHALL be dropped, not queued, and SHALL set o_overrun.
REQ-026 A read response SHALL be accepted in IDLE the cycle after o_tx_dval, allowing back-to-back reads.

Reset
REQ-027 Asserting reset SHALL clear all outputs to 0, put the FSM in IDLE, and clear the counter, o_timeout_cnt and o_overrun.
REQ-028 Reset mid-read SHALL abandon the read with no o_tx_dval; a late i_rd_dval after reset SHALL be ignored.

Structure
REQ-029 FSM state encoding and the ERR_DATA default SHALL live in shared package lb_pkg.
REQ-030 Per-target decode and read-mux MAY form one sub-module, lb_sel_decode; the FSM and counters SHALL stay in lb_target_router.

Verification
REQ-031 Write addr 0x0000_0104, data 0x1234_5678 -> o_wr_en=4'b0010 at cycle 1 only, o_wr_addr/o_wr_data match.
REQ-032 Read 0x0000_0300; target 3 returns 0xA5A5_0003 four cycles after o_rd_req -> o_tx_dval one cycle later with 0xA5A5_0003; o_busy falls.
REQ-033 Read target 2 with no response, TIMEOUT=16 -> o_tx_data=0xDEAD_BEEF after 16 wait cycles; o_timeout_cnt=1.
REQ-034 N_TGT=3, read 0x0000_0300 -> no o_rd_req, o_tx_dval at cycle 2 with 0xDEAD_BEEF; write to same address -> o_wr_en stays 0.
REQ-035 Second i_tx_req during WAIT plus target 1 i_rd_dval while target 0 is selected -> both ignored; o_overrun=1; only one o_tx_dval.
REQ-036 Reset asserted during WAIT, then target i_rd_dval -> no o_tx_dval; o_busy=0; all status cleared.
